// File: rtl/fp8_dot_acc_if.sv
// Beat/result bus for the multi-lane FP8 dot-product accumulator.
// The master drives beats and result-ready; the slave is the accumulator.
interface fp8_dot_acc_if #(
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               in_first;
  logic               in_last;
  logic [8*LANES-1:0] in_a;
  logic [8*LANES-1:0] in_b;
  logic [15:0]        in_bias;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [1:0]         out_flags;

  modport master (
    output in_valid, in_first, in_last, in_a, in_b, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_first, in_last, in_a, in_b, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp8_dot_acc.sv
// Pipelined multi-lane E5M2 dot-product accumulator with FP16 bias and a
// single RNE rounding to FP32 at the end of each burst.
// Internal arithmetic is exact two's complement fixed point scaled by 2^34.

// One lane: decode an E5M2 pair and form the exact signed product.
module fp8_dot_acc_lane #(
  parameter int PW = 67
) (
  input  logic [7:0]    a,
  input  logic [7:0]    b,
  output logic [PW-1:0] prod,
  output logic          nan,
  output logic          pinf,
  output logic          ninf
);
  logic [4:0]    ea, eb, ea_eff, eb_eff;
  logic [2:0]    ma, mb;
  logic          a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
  logic          sgn, inf;
  logic [5:0]    mm, sh;
  logic [PW-1:0] mag;

  // Subnormals use hidden bit 0 and effective exponent 1; specials give no
  // finite contribution and are reported through the flags instead.
  always_comb begin
    ea     = a[6:2];
    eb     = b[6:2];
    ea_eff = (ea == 5'd0) ? 5'd1 : ea;
    eb_eff = (eb == 5'd0) ? 5'd1 : eb;
    ma     = {ea != 5'd0, a[1:0]};
    mb     = {eb != 5'd0, b[1:0]};
    a_inf  = (ea == 5'd31) && (a[1:0] == 2'd0);
    b_inf  = (eb == 5'd31) && (b[1:0] == 2'd0);
    a_nan  = (ea == 5'd31) && (a[1:0] != 2'd0);
    b_nan  = (eb == 5'd31) && (b[1:0] != 2'd0);
    a_zero = (a[6:0] == 7'd0);
    b_zero = (b[6:0] == 7'd0);
    sgn    = a[7] ^ b[7];
    mm     = {3'd0, ma} * {3'd0, mb};
    sh     = {1'b0, ea_eff} + {1'b0, eb_eff};
    mag    = PW'(mm) << sh;
    if (ea == 5'd31 || eb == 5'd31) mag = '0;
    prod   = sgn ? -mag : mag;
    nan    = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    inf    = (a_inf | b_inf) & ~nan;
    pinf   = inf & ~sgn;
    ninf   = inf & sgn;
  end
endmodule

module fp8_dot_acc #(
  parameter int LANES = 4,
  parameter int GUARD = 8
) (
  input  logic         clk,
  input  logic         rst,
  fp8_dot_acc_if.slave bus
);
  localparam int PW    = 67;
  localparam int ACC_W = PW + GUARD;
  localparam int LW    = $clog2(ACC_W);

  typedef struct packed {
    logic             first;
    logic             last;
    logic             nan;
    logic             pinf;
    logic             ninf;
    logic [ACC_W-1:0] bias;
  } s1_t;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             nan;
    logic             pinf;
    logic             ninf;
  } acc_t;

  logic                     en;
  logic [1:0]               vld_pipe;
  logic [LANES-1:0][PW-1:0] lane_prod, s1_prod;
  logic [LANES-1:0]         lane_nan, lane_pinf, lane_ninf;
  s1_t                      s1;
  acc_t                     acc_q, acc_next, s2;
  logic [ACC_W-1:0]         lane_sum;

  logic [4:0]               b_exp;
  logic [10:0]              b_sig;
  logic [5:0]               b_sh;
  logic                     b_special, b_nan, b_pinf, b_ninf;
  logic [ACC_W-1:0]         b_mag, bias_al;

  logic                     neg;
  logic [ACC_W-1:0]         mag, norm;
  logic [LW-1:0]            lead;
  logic [23:0]              sig;
  logic                     grd, stk;
  logic [24:0]              rnd;
  logic [7:0]               exp8;
  logic [31:0]              res_data;
  logic [1:0]               res_flags;

  logic                     out_valid_q;
  logic [31:0]              out_data_q;
  logic [1:0]               out_flags_q;

  // Whole pipeline advances together; a held result freezes every stage.
  assign en            = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp8_dot_acc_lane #(.PW(PW)) u_lane (
      .a    (bus.in_a[8*i +: 8]),
      .b    (bus.in_b[8*i +: 8]),
      .prod (lane_prod[i]),
      .nan  (lane_nan[i]),
      .pinf (lane_pinf[i]),
      .ninf (lane_ninf[i])
    );
  end

  // FP16 bias aligned onto the same 2^-34 grid (its 2^-24 LSB lands at bit 10).
  always_comb begin
    b_exp     = bus.in_bias[14:10];
    b_sig     = {b_exp != 5'd0, bus.in_bias[9:0]};
    b_sh      = ((b_exp == 5'd0) ? 6'd1 : {1'b0, b_exp}) + 6'd9;
    b_special = (b_exp == 5'd31);
    b_mag     = ACC_W'(b_sig) << b_sh;
    if (b_special) b_mag = '0;
    bias_al   = bus.in_bias[15] ? -b_mag : b_mag;
    b_nan     = b_special & (bus.in_bias[9:0] != 10'd0);
    b_pinf    = b_special & (bus.in_bias[9:0] == 10'd0) & ~bus.in_bias[15];
    b_ninf    = b_special & (bus.in_bias[9:0] == 10'd0) & bus.in_bias[15];
  end

  // S1: register lane products, aligned bias and per-beat special flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[0] <= 1'b0;
      s1          <= '0;
      s1_prod     <= '0;
    end else if (en) begin
      vld_pipe[0] <= bus.in_valid;
      if (bus.in_valid) begin
        s1.first <= bus.in_first;
        s1.last  <= bus.in_last;
        s1.nan   <= (|lane_nan) | (bus.in_first & b_nan);
        s1.pinf  <= (|lane_pinf) | (bus.in_first & b_pinf);
        s1.ninf  <= (|lane_ninf) | (bus.in_first & b_ninf);
        s1.bias  <= bias_al;
        s1_prod  <= lane_prod;
      end
    end
  end

  // Exact beat sum; a first beat restarts from the bias and fresh flags.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + ACC_W'(signed'(s1_prod[i]));
    acc_next.acc  = (s1.first ? s1.bias : acc_q.acc) + lane_sum;
    acc_next.nan  = (s1.first ? 1'b0 : acc_q.nan)  | s1.nan;
    acc_next.pinf = (s1.first ? 1'b0 : acc_q.pinf) | s1.pinf;
    acc_next.ninf = (s1.first ? 1'b0 : acc_q.ninf) | s1.ninf;
  end

  // S2: running accumulator; a last beat hands the total on and clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      acc_q       <= '0;
      s2          <= '0;
    end else if (en) begin
      vld_pipe[1] <= vld_pipe[0] & s1.last;
      if (vld_pipe[0]) begin
        if (s1.last) begin
          acc_q <= '0;
          s2    <= acc_next;
        end else begin
          acc_q <= acc_next;
        end
      end
    end
  end

  // Normalise and round once to FP32 (RNE); specials override the number.
  always_comb begin
    neg  = s2.acc[ACC_W-1];
    mag  = neg ? -s2.acc : s2.acc;
    lead = '0;
    for (int i = 0; i < ACC_W; i++)
      if (mag[i]) lead = LW'(i);
    norm = mag << (LW'(ACC_W - 1) - lead);
    sig  = norm[ACC_W-1 -: 24];
    grd  = norm[ACC_W-25];
    stk  = |norm[ACC_W-26:0];
    rnd  = {1'b0, sig} + {24'd0, grd & (stk | sig[0])};
    exp8 = 8'(lead) + 8'd93 + {7'd0, rnd[24]};
    res_flags = 2'b00;
    if (mag == '0) res_data = 32'h0000_0000;
    else           res_data = {neg, exp8, rnd[24] ? rnd[23:1] : rnd[22:0]};
    if (s2.nan || (s2.pinf && s2.ninf)) begin
      res_data  = 32'h7FC0_0000;
      res_flags = 2'b10;
    end else if (s2.pinf) begin
      res_data  = 32'h7F80_0000;
      res_flags = 2'b01;
    end else if (s2.ninf) begin
      res_data  = 32'hFF80_0000;
      res_flags = 2'b01;
    end
  end

  // S3: result register; it drops on handshake unless a new result arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else if (en) begin
      out_valid_q <= vld_pipe[1];
      if (vld_pipe[1]) begin
        out_data_q  <= res_data;
        out_flags_q <= res_flags;
      end
    end
  end
endmodule

// File: tb/tb_fp8_dot_acc.sv
// Randomised and directed bench for fp8_dot_acc with an arithmetic reference.
module tb_fp8_dot_acc;
  localparam int LANES = 4;
  localparam int GUARD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp8_dot_acc_if #(.LANES(LANES)) bus();
  fp8_dot_acc #(.LANES(LANES), .GUARD(GUARD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [33:0] res_q[$];
  logic [33:0] exp_q[$];
  bit rnd_bp = 1'b0;

  logic signed [127:0] m_acc = '0;
  bit m_nan = 0, m_pinf = 0, m_ninf = 0;

  // Collect every delivered result {flags, data}.
  always @(posedge clk)
    if (!rst && bus.out_valid && bus.out_ready) res_q.push_back({bus.out_flags, bus.out_data});

  // Random result backpressure while enabled.
  initial forever begin
    @(posedge clk); #2;
    if (rnd_bp) bus.out_ready = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Operand value times 2^17 (E5M2 value = significand * 2^(e-17)).
  function automatic logic [127:0] op_val17(input logic [7:0] x);
    int e;
    e = int'(x[6:2]);
    if (e == 0) return 128'(x[1:0]) * 2;
    return 128'(32'd4 + x[1:0]) << e;
  endfunction

  // Exact value to FP32 with round-half-even done by remainder comparison.
  function automatic logic [33:0] ref_result(input logic signed [127:0] v, input bit nan, pinf, ninf);
    logic [127:0] m, q, rem, half;
    int e;
    if (nan || (pinf && ninf)) return {2'b10, 32'h7FC00000};
    if (pinf) return {2'b01, 32'h7F800000};
    if (ninf) return {2'b01, 32'hFF800000};
    if (v == 0) return 34'd0;
    m = (v < 0) ? -v : v;
    e = 0;
    while (e < 126 && (m >> (e + 1)) != 0) e++;
    if (e <= 23) q = m << (23 - e);
    else begin
      q    = m >> (e - 23);
      rem  = m - (q << (e - 23));
      half = 128'd1 << (e - 24);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (128'd1 << 24)) begin q = q >> 1; e++; end
    end
    return {2'b00, (v < 0), 8'(e + 93), q[22:0]};
  endfunction

  task automatic model_clear();
    m_acc = '0; m_nan = 0; m_pinf = 0; m_ninf = 0;
  endtask

  task automatic model_beat(input bit first, last, input logic [31:0] a, b, input logic [15:0] bias);
    logic [127:0] v;
    logic [7:0] x, y;
    int be;
    bit xn, yn, xi, yi, xz, yz;
    if (first) begin
      model_clear();
      be = int'(bias[14:10]);
      if (be == 31) begin
        if (bias[9:0] != 0) m_nan = 1;
        else if (bias[15]) m_ninf = 1;
        else m_pinf = 1;
      end else begin
        v = (be == 0) ? (128'(bias[9:0]) << 10) : (128'(32'd1024 + bias[9:0]) << (be + 9));
        m_acc = bias[15] ? -v : v;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      x = a[8*i +: 8]; y = b[8*i +: 8];
      xn = (x[6:2] == 31) && (x[1:0] != 0); yn = (y[6:2] == 31) && (y[1:0] != 0);
      xi = (x[6:2] == 31) && (x[1:0] == 0); yi = (y[6:2] == 31) && (y[1:0] == 0);
      xz = (x[6:0] == 0); yz = (y[6:0] == 0);
      if (xn || yn || (xi && yz) || (yi && xz)) m_nan = 1;
      else if (xi || yi) begin
        if (x[7] ^ y[7]) m_ninf = 1; else m_pinf = 1;
      end else begin
        v = op_val17(x) * op_val17(y);
        m_acc = (x[7] ^ y[7]) ? m_acc - v : m_acc + v;
      end
    end
    if (last) begin
      exp_q.push_back(ref_result(m_acc, m_nan, m_pinf, m_ninf));
      model_clear();
    end
  endtask

  // Drive one beat; returns one cycle-fraction after the accepting edge.
  task automatic send(input bit first, last, input logic [31:0] a, b, input logic [15:0] bias);
    int n = 0;
    @(negedge clk);
    bus.in_first = first; bus.in_last = last;
    bus.in_a = a; bus.in_b = b; bus.in_bias = bias;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 500) begin @(negedge clk); #1; n++; end
    if (n >= 500) begin
      errors++;
      $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic beat(input bit first, last, input logic [31:0] a, b, input logic [15:0] bias);
    send(first, last, a, b, bias);
    model_beat(first, last, a, b, bias);
  endtask

  task automatic get_result(output bit got, output logic [33:0] r);
    int n = 0;
    got = 0; r = '0;
    while (res_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    if (res_q.size() != 0) begin got = 1; r = res_q.pop_front(); end
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0;
    bus.in_a = '0; bus.in_b = '0; bus.in_bias = '0; bus.out_ready = 1;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
    checks++; if (bus.out_flags !== 2'd0) begin errors++; $display("FAIL reset_out_flags got %b exp 0", bus.out_flags); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    int k = 0;
    bit got; logic [33:0] r;
    beat(1, 1, {4{8'h3C}}, {4{8'h40}}, 16'h3C00);
    while (k < 20) begin @(negedge clk); k++; if (bus.out_valid) break; end
    checks++; if (k != 3) begin errors++; $display("FAIL single_latency got %0d cycles exp 3", k); end
    get_result(got, r);
    checks++; if (!got || r !== {2'b00, 32'h41100000}) begin errors++; $display("FAIL single_sum got %0b/%h exp 1/%h", got, r, {2'b00, 32'h41100000}); end
  endtask

  task automatic test_cancel();
    bit got; logic [33:0] r;
    beat(1, 0, {4{8'h3C}}, {4{8'h3C}}, 16'h0000);
    beat(0, 1, {4{8'hBC}}, {4{8'h3C}}, 16'h0000);
    get_result(got, r);
    checks++; if (!got || r !== 34'd0) begin errors++; $display("FAIL cancel got %0b/%h exp 1/0", got, r); end
  endtask

  task automatic test_rounding();
    bit got; logic [33:0] r;
    beat(1, 1, 32'h0000010C, 32'h0000010C, 16'h3C00);
    get_result(got, r);
    checks++; if (!got || r !== {2'b00, 32'h3F800001}) begin errors++; $display("FAIL round_sticky got %0b/%h exp 3f800001", got, r); end
    beat(1, 1, 32'h0000000C, 32'h0000000C, 16'h3C00);
    get_result(got, r);
    checks++; if (!got || r !== {2'b00, 32'h3F800000}) begin errors++; $display("FAIL round_tie got %0b/%h exp 3f800000", got, r); end
    beat(1, 1, {4{8'hBC}}, {4{8'h3C}}, 16'h0000);
    get_result(got, r);
    checks++; if (!got || r !== {2'b00, 32'hC0800000}) begin errors++; $display("FAIL negative got %0b/%h exp c0800000", got, r); end
  endtask

  task automatic test_specials();
    bit got; logic [33:0] r;
    beat(1, 1, 32'h0000007C, 32'h00000000, 16'h0000);
    get_result(got, r);
    checks++; if (!got || r !== {2'b10, 32'h7FC00000}) begin errors++; $display("FAIL inf_times_zero got %0b/%h exp 2/7fc00000", got, r); end
    beat(1, 0, 32'h0000007C, 32'h0000003C, 16'h0000);
    beat(0, 1, 32'h000000FC, 32'h0000003C, 16'h0000);
    get_result(got, r);
    checks++; if (!got || r !== {2'b10, 32'h7FC00000}) begin errors++; $display("FAIL inf_minus_inf got %0b/%h exp 2/7fc00000", got, r); end
    beat(1, 1, 32'h0000007C, 32'h0000003C, 16'h0000);
    get_result(got, r);
    checks++; if (!got || r !== {2'b01, 32'h7F800000}) begin errors++; $display("FAIL pos_inf got %0b/%h exp 1/7f800000", got, r); end
    beat(1, 1, 32'h0000007C, 32'h000000BC, 16'h3C00);
    get_result(got, r);
    checks++; if (!got || r !== {2'b01, 32'hFF800000}) begin errors++; $display("FAIL neg_inf got %0b/%h exp 1/ff800000", got, r); end
    beat(1, 1, 32'h00003C00, 32'h00007D00, 16'h0000);
    get_result(got, r);
    checks++; if (!got || r !== {2'b10, 32'h7FC00000}) begin errors++; $display("FAIL nan_operand got %0b/%h exp 2/7fc00000", got, r); end
    beat(1, 1, 32'h0, 32'h0, 16'hFC00);
    get_result(got, r);
    checks++; if (!got || r !== {2'b01, 32'hFF800000}) begin errors++; $display("FAIL bias_inf got %0b/%h exp 1/ff800000", got, r); end
    beat(1, 1, 32'h0000003C, 32'h0000003C, 16'h0000);
    get_result(got, r);
    checks++; if (!got || r !== {2'b00, 32'h3F800000}) begin errors++; $display("FAIL sticky_cleared got %0b/%h exp 0/3f800000", got, r); end
  endtask

  task automatic test_backpressure();
    bit got; logic [33:0] r;
    @(negedge clk); bus.out_ready = 0;
    beat(1, 1, {4{8'h3C}}, {4{8'h3C}}, 16'h0000);
    beat(1, 1, {4{8'h40}}, {4{8'h40}}, 16'h0000);
    repeat (4) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h40800000) begin errors++; $display("FAIL bp_held got v=%b %h exp v=1 40800000", bus.out_valid, bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (bus.out_data !== 32'h40800000 || res_q.size() != 0) begin errors++; $display("FAIL bp_stable got %h q=%0d exp 40800000 q=0", bus.out_data, res_q.size()); end
    bus.out_ready = 1;
    repeat (10) @(negedge clk);
    checks++; if (res_q.size() != 2) begin errors++; $display("FAIL bp_count got %0d exp 2", res_q.size()); end
    get_result(got, r);
    checks++; if (!got || r !== {2'b00, 32'h40800000}) begin errors++; $display("FAIL bp_first got %0b/%h exp 40800000", got, r); end
    get_result(got, r);
    checks++; if (!got || r !== {2'b00, 32'h41800000}) begin errors++; $display("FAIL bp_second got %0b/%h exp 41800000", got, r); end
  endtask

  task automatic test_reset_midburst();
    bit got; logic [33:0] r;
    @(negedge clk); bus.out_ready = 0;
    beat(1, 1, {4{8'h3C}}, {4{8'h3C}}, 16'h0000);
    beat(1, 0, 32'h3C3C3C7C, {4{8'h3C}}, 16'h3C00);
    beat(0, 0, {4{8'h40}}, {4{8'h40}}, 16'h0000);
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b exp 1", bus.out_valid); end
    #2 rst = 1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_flags !== 2'd0) begin errors++; $display("FAIL rstmid_async got v=%b %h f=%b exp 0", bus.out_valid, bus.out_data, bus.out_flags); end
    @(negedge clk); rst = 0;
    res_q.delete(); model_clear(); bus.out_ready = 1;
    beat(0, 1, 32'h0000003C, 32'h0000003C, 16'h4000);
    get_result(got, r);
    checks++; if (!got || r !== {2'b00, 32'h3F800000}) begin errors++; $display("FAIL rstmid_fresh got %0b/%h exp 0/3f800000", got, r); end
    repeat (8) @(negedge clk);
    checks++; if (res_q.size() != 0) begin errors++; $display("FAIL rstmid_stale got %0d extra results exp 0", res_q.size()); end
  endtask

  function automatic logic [7:0] rand_op();
    if ($urandom_range(0, 19) == 0) begin
      case ($urandom_range(0, 3))
        0: return 8'h7C;
        1: return 8'hFC;
        2: return 8'h7E;
        default: return 8'h00;
      endcase
    end
    return {1'($urandom), 5'($urandom_range(0, 30)), 2'($urandom)};
  endfunction

  task automatic test_random();
    int len, n;
    logic [31:0] a, b;
    logic [15:0] bias;
    res_q.delete(); exp_q.delete(); model_clear();
    rnd_bp = 1;
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        for (int l = 0; l < LANES; l++) begin a[8*l +: 8] = rand_op(); b[8*l +: 8] = rand_op(); end
        bias = {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
        if ($urandom_range(0, 24) == 0) bias = 16'h7C00;
        beat((j == 0) && ($urandom_range(0, 4) != 0), j == len - 1, a, b, bias);
      end
    end
    rnd_bp = 0;
    @(negedge clk); bus.out_ready = 1;
    n = 0;
    while (res_q.size() < exp_q.size() && n < 2000) begin @(negedge clk); n++; end
    checks++; if (res_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", res_q.size(), exp_q.size()); end
    while (res_q.size() != 0 && exp_q.size() != 0) begin
      logic [33:0] g, e;
      g = res_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rand_result got %h exp %h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_cancel();
    test_rounding();
    test_specials();
    test_backpressure();
    test_reset_midburst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
